// File: rtl/fdn_pkg.sv
// Shared types and sizing helpers for the FDN coefficient loader.
package fdn_pkg;

    typedef enum logic [1:0] {Idle, Run, Drain} fdn_state_e;

    localparam int unsigned FifoDepth = 2;

    function automatic int unsigned fdn_len(input int unsigned n_ch, input int unsigned n_dn);
        return n_ch * n_dn;
    endfunction

    function automatic int unsigned fdn_addr_w(input int unsigned n_ch, input int unsigned n_dn,
                                               input int unsigned n_banks);
        return $clog2(n_banks * n_ch * n_dn);
    endfunction

endpackage

// File: rtl/fdn_skid_fifo2.sv
// Two-entry FIFO with synchronous flush; head word is visible on rdata_o while valid_o is high.
module fdn_skid_fifo2
    import fdn_pkg::*;
#(
    parameter int unsigned Width = 33
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [Width-1:0] mem_q [FifoDepth];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (cnt_q != 2'd0);
        do_push  = push_i && ((cnt_q != 2'(FifoDepth)) || do_pop);
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        cnt_d    = cnt_q + 2'(do_push) - 2'(do_pop);
        if (flush_i) begin
            do_push  = 1'b0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            for (int i = 0; i < FifoDepth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = (cnt_q != 2'd0);
    assign count_o = cnt_q;

endmodule

// File: rtl/fdn_coef_loader.sv
// Streams one bank of beam-steering coefficients from a synchronous RAM to the core's
// AXI-Stream coefficient input, with credit-based reads into a two-entry output buffer.
module fdn_coef_loader
    import fdn_pkg::*;
#(
    parameter int unsigned wight_coef_i = 16,
    parameter int unsigned N_chanals    = 16,
    parameter int unsigned N_DN         = 4,
    parameter int unsigned N_banks      = 4
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  start,
    input  logic [$clog2(N_banks)-1:0]                            bank,
    input  logic                                                  abort,
    output logic                                                  busy,
    output logic                                                  done,
    output logic                                                  err,
    output logic                                                  mem_rd_en,
    output logic [fdn_addr_w(N_chanals, N_DN, N_banks)-1:0]       mem_addr,
    input  logic [2*wight_coef_i-1:0]                             mem_rdata,
    output logic                                                  vld_coef_out,
    input  logic                                                  readi_coef_out,
    output logic                                                  last_coef_out,
    output logic [wight_coef_i-1:0]                               coefReOut,
    output logic [wight_coef_i-1:0]                               coefImOut
);

    localparam int unsigned L     = fdn_len(N_chanals, N_DN);
    localparam int unsigned AddrW = fdn_addr_w(N_chanals, N_DN, N_banks);
    localparam int unsigned CntW  = $clog2(L + 1);
    localparam int unsigned DataW = 2 * wight_coef_i;

    fdn_state_e       state_q, state_d;
    logic [CntW-1:0]  rk_q, rk_d;
    logic [CntW-1:0]  ok_q, ok_d;
    logic [AddrW-1:0] base_q, base_d;
    logic             inflight_q, inflight_d;
    logic             last_inf_q, last_inf_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             rd_en;
    logic             pop;
    logic             credit;
    logic             bank_ok;
    logic             fifo_flush;
    logic             fifo_valid;
    logic [1:0]       fifo_cnt;
    logic [DataW:0]   fifo_rdata;

    assign pop     = fifo_valid && readi_coef_out;
    assign bank_ok = (32'(bank) < N_banks);
    // Buffered words plus the in-flight read, less this cycle's pop, must leave room for one more.
    assign credit  = (({1'b0, fifo_cnt} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_d    = state_q;
        rk_d       = rk_q;
        ok_d       = ok_q + CntW'(pop);
        base_d     = base_q;
        rd_en      = 1'b0;
        last_inf_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        fifo_flush = 1'b0;

        unique case (state_q)
            Idle: begin
                if (start) begin
                    if (bank_ok) begin
                        state_d = Run;
                        rk_d    = '0;
                        ok_d    = '0;
                        base_d  = AddrW'(32'(bank) * L);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            Run: begin
                if (abort) begin
                    state_d    = Idle;
                    fifo_flush = 1'b1;
                end else if (credit) begin
                    rd_en      = 1'b1;
                    rk_d       = rk_q + CntW'(1);
                    last_inf_d = (rk_q == CntW'(L - 1));
                    if (rk_q == CntW'(L - 1)) begin
                        state_d = Drain;
                    end
                end
            end
            Drain: begin
                if (abort) begin
                    state_d    = Idle;
                    fifo_flush = 1'b1;
                end else if ((ok_d == CntW'(L)) && !inflight_q && (fifo_cnt == 2'(pop))) begin
                    state_d = Idle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = Idle;
        endcase

        if (start && (state_q != Idle)) begin
            err_d = 1'b1;
        end
        inflight_d = rd_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= Idle;
            rk_q       <= '0;
            ok_q       <= '0;
            base_q     <= '0;
            inflight_q <= 1'b0;
            last_inf_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rk_q       <= rk_d;
            ok_q       <= ok_d;
            base_q     <= base_d;
            inflight_q <= inflight_d;
            last_inf_q <= last_inf_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // An abort flushes in the same edge the in-flight result would land, so it is discarded.
    fdn_skid_fifo2 #(
        .Width (DataW + 1)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (fifo_flush),
        .push_i  (inflight_q),
        .wdata_i ({last_inf_q, mem_rdata}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .valid_o (fifo_valid),
        .count_o (fifo_cnt)
    );

    assign busy          = (state_q != Idle);
    assign done          = done_q;
    assign err           = err_q;
    assign mem_rd_en     = rd_en;
    assign mem_addr      = rd_en ? (base_q + AddrW'(rk_q)) : '0;
    assign vld_coef_out  = fifo_valid;
    assign last_coef_out = fifo_valid && fifo_rdata[DataW];
    assign coefReOut     = fifo_valid ? fifo_rdata[wight_coef_i-1:0] : '0;
    assign coefImOut     = fifo_valid ? fifo_rdata[DataW-1:wight_coef_i] : '0;

endmodule

// File: tb/tb_fdn_coef_loader.sv
// Directed bench for fdn_coef_loader with L=8; RAM word n holds Re=n, Im=-n.
module tb_fdn_coef_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [0:0]  bank = 1'b0;
    logic        abort = 1'b0;
    logic        readi = 1'b0;
    logic        busy, done, err, mem_rd_en, vld, last;
    logic [3:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [15:0] re, im;

    logic        start_b = 1'b0;
    logic [1:0]  bank_b = 2'd0;
    logic        busy_b, done_b, err_b, rd_en_b, vld_b, last_b;
    logic [4:0]  addr_b;
    logic [15:0] re_b, im_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= {16'd0 - {12'd0, mem_addr}, {12'd0, mem_addr}};
        end
    end

    fdn_coef_loader #(
        .wight_coef_i (16),
        .N_chanals    (4),
        .N_DN         (2),
        .N_banks      (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .bank           (bank),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .vld_coef_out   (vld),
        .readi_coef_out (readi),
        .last_coef_out  (last),
        .coefReOut      (re),
        .coefImOut      (im)
    );

    // Three banks give a 2-bit bank port, so an out-of-range bank can be driven.
    fdn_coef_loader #(
        .wight_coef_i (16),
        .N_chanals    (4),
        .N_DN         (2),
        .N_banks      (3)
    ) dut_b (
        .clk            (clk),
        .rst            (rst),
        .start          (start_b),
        .bank           (bank_b),
        .abort          (1'b0),
        .busy           (busy_b),
        .done           (done_b),
        .err            (err_b),
        .mem_rd_en      (rd_en_b),
        .mem_addr       (addr_b),
        .mem_rdata      (32'd0),
        .vld_coef_out   (vld_b),
        .readi_coef_out (1'b1),
        .last_coef_out  (last_b),
        .coefReOut      (re_b),
        .coefImOut      (im_b)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full load with a scoreboard; bp selects the 1,0,0,1 tready pattern,
    // poke issues a start with the other bank while busy.
    task automatic load_and_check(input logic bk, input bit bp, input bit poke);
        int          base;
        int          issued;
        int          exp_k;
        bit          fin;
        bit          held;
        logic [15:0] held_re;
        logic        held_last;
        logic [15:0] e_im;
        base      = bk ? 8 : 0;
        issued    = 0;
        exp_k     = 0;
        fin       = 1'b0;
        held      = 1'b0;
        held_re   = '0;
        held_last = 1'b0;
        cyc();
        start = 1'b1;
        bank  = bk;
        abort = 1'b0;
        readi = 1'b1;
        for (int c = 1; c < 200 && !fin; c++) begin
            cyc();
            start = poke && (c == 4);
            bank  = (poke && (c == 4)) ? ~bk : bk;
            readi = bp ? (((c - 1) % 4 == 0) || ((c - 1) % 4 == 3)) : 1'b1;
            #1;
            if (held) begin
                chk("hold_vld", 32'(vld), 1);
                chk("hold_re", 32'(re), 32'(held_re));
                chk("hold_last", 32'(last), 32'(held_last));
            end
            if (mem_rd_en) begin
                chk("rd_addr", 32'(mem_addr), base + issued);
                issued++;
            end
            if (vld && readi) begin
                e_im = 16'(-(base + exp_k));
                chk("word_re", 32'(re), base + exp_k);
                chk("word_im", 32'(im), 32'(e_im));
                chk("word_last", 32'(last), 32'(exp_k == 7));
                exp_k++;
            end
            held      = vld && !readi;
            held_re   = re;
            held_last = last;
            chk("credit_max", 32'((issued - exp_k) <= 2), 1);
            if (busy && !mem_rd_en && issued < 8) begin
                chk("credit_stall", issued - exp_k, 2);
            end
            chk("err_pulse", 32'(err), 32'(poke && (c == 5)));
            if (done) begin
                fin = 1'b1;
                chk("word_count", exp_k, 8);
                chk("done_busy", 32'(busy), 0);
            end
        end
        chk("done_seen", 32'(fin), 1);
        cyc();
        #1;
        chk("done_width", 32'(done), 0);
        chk("idle_after", 32'(busy), 0);
    endtask

    initial begin
        logic [15:0] e_im;

        // Reset values
        cyc();
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rd_en", 32'(mem_rd_en), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_vld", 32'(vld), 0);
        chk("rst_last", 32'(last), 0);
        chk("rst_re", 32'(re), 0);
        chk("rst_im", 32'(im), 0);
        cyc();
        rst = 1'b0;

        // 1. Continuous load of bank 1, cycle-exact
        cyc();
        start = 1'b1;
        bank  = 1'b1;
        readi = 1'b1;
        #1;
        chk("c0_busy", 32'(busy), 0);
        cyc();
        start = 1'b0;
        #1;
        chk("c1_busy", 32'(busy), 1);
        chk("c1_rd_en", 32'(mem_rd_en), 1);
        chk("c1_addr", 32'(mem_addr), 8);
        chk("c1_vld", 32'(vld), 0);
        cyc();
        #1;
        chk("c2_vld", 32'(vld), 0);
        chk("c2_addr", 32'(mem_addr), 9);
        for (int i = 0; i < 8; i++) begin
            cyc();
            #1;
            e_im = 16'(-(8 + i));
            chk("c_vld", 32'(vld), 1);
            chk("c_re", 32'(re), 8 + i);
            chk("c_im", 32'(im), 32'(e_im));
            chk("c_last", 32'(last), 32'(i == 7));
            chk("c_done", 32'(done), 0);
        end
        cyc();
        #1;
        chk("c11_done", 32'(done), 1);
        chk("c11_busy", 32'(busy), 0);
        chk("c11_vld", 32'(vld), 0);
        cyc();
        #1;
        chk("c12_done", 32'(done), 0);

        // 2. Back-pressure 1,0,0,1
        load_and_check(1'b0, 1'b1, 1'b0);

        // 3. Start while busy
        load_and_check(1'b1, 1'b0, 1'b1);

        // 4. Out-of-range bank on the three-bank instance
        cyc();
        start_b = 1'b1;
        bank_b  = 2'd3;
        #1;
        chk("bad_busy0", 32'(busy_b), 0);
        cyc();
        start_b = 1'b0;
        bank_b  = 2'd0;
        #1;
        chk("bad_err", 32'(err_b), 1);
        chk("bad_busy1", 32'(busy_b), 0);
        chk("bad_rd_en1", 32'(rd_en_b), 0);
        cyc();
        #1;
        chk("bad_err_w", 32'(err_b), 0);
        chk("bad_busy2", 32'(busy_b), 0);
        chk("bad_rd_en2", 32'(rd_en_b), 0);
        chk("bad_out", 32'({vld_b, last_b, done_b, addr_b, re_b, im_b} == '0), 1);

        // 5. Abort after three handshakes
        cyc();
        start = 1'b1;
        bank  = 1'b1;
        readi = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            start = 1'b0;
        end
        #1;
        chk("ab_re3", 32'(re), 10);
        cyc();
        readi = 1'b0;
        abort = 1'b1;
        #1;
        chk("ab_vld_pre", 32'(vld), 1);
        chk("ab_busy_pre", 32'(busy), 1);
        cyc();
        abort = 1'b0;
        readi = 1'b1;
        #1;
        chk("ab_vld", 32'(vld), 0);
        chk("ab_busy", 32'(busy), 0);
        chk("ab_done", 32'(done), 0);
        for (int c = 0; c < 3; c++) begin
            cyc();
            #1;
            chk("ab_quiet", 32'({vld, done, mem_rd_en}), 0);
        end
        load_and_check(1'b0, 1'b0, 1'b0);

        // 6. Asynchronous reset at word 5
        cyc();
        start = 1'b1;
        bank  = 1'b1;
        readi = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            start = 1'b0;
        end
        #1;
        chk("rm_re5", 32'(re), 13);
        rst = 1'b1;
        #1;
        chk("rm_vld", 32'(vld), 0);
        chk("rm_busy", 32'(busy), 0);
        chk("rm_rd_en", 32'(mem_rd_en), 0);
        chk("rm_addr", 32'(mem_addr), 0);
        chk("rm_re", 32'(re), 0);
        chk("rm_im", 32'(im), 0);
        chk("rm_last", 32'(last), 0);
        chk("rm_flags", 32'({done, err}), 0);
        cyc();
        rst = 1'b0;
        load_and_check(1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
